// File: rtl/mmio_dbg_ctrl.sv
// MMIO slave for the 256-byte debug/telemetry window: counters, trace status, trace RAM reads via index.
// Latency: register read / any write ack at T+1; trace read strobes RAM at T and acks at T+2 (T = accept cycle).
// Backpressure: one outstanding request; mem_accept_o low in RAM_WAIT/RESP, the bus must hold or retry.
// Ports: clk_i/rst_i (sync, active-high); mem_* request/response bus; mcycle_i/minstret_i/stall_i live
//   counters; trace_* status inputs, RAM read strobe/index out, RAM data in (valid 1 cycle after strobe).
// Optional: define MMIO_SNAPSHOT_EN for coherent 64-bit counter reads (lo read latches hi into a shadow).
module mmio_dbg_ctrl #(
   parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
   parameter int          TRACE_DEPTH_W = 6
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [31:0]              mem_addr_i,
   input  logic [31:0]              mem_data_wr_i,
   input  logic                     mem_rd_i,
   input  logic [3:0]               mem_wr_i,
   output logic                     mem_accept_o,
   output logic                     mem_ack_o,
   output logic                     mem_error_o,
   output logic [31:0]              mem_data_rd_o,
   input  logic [63:0]              mcycle_i,
   input  logic [63:0]              minstret_i,
   input  logic [63:0]              stall_i,
   input  logic                     trace_triggered_i,
   input  logic [TRACE_DEPTH_W-1:0] trace_wr_ptr_i,
   output logic                     trace_rd_en_o,
   output logic [TRACE_DEPTH_W-1:0] trace_rd_addr_o,
   input  logic [31:0]              trace_rd_pc_i,
   input  logic [31:0]              trace_rd_instr_i
);

   typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

   state_t                   state_q, state_d;
   logic [TRACE_DEPTH_W-1:0] index_q;
   logic [31:0]              rdata_q;
   logic                     err_q;
   logic                     sel_instr_q;   // remembers 0x2C vs 0x28 across RAM_WAIT

   logic       is_wr, hit;
   logic [7:0] off;
   logic       rd_en, idx_we, resp_ld, resp_err;
   logic [31:0] resp_dat;

   logic unused_wdata;
   assign unused_wdata = ^mem_data_wr_i[31:TRACE_DEPTH_W];

   assign is_wr = |mem_wr_i;
   assign hit   = (mem_rd_i | is_wr) && (mem_addr_i[31:8] == BASE_ADDR[31:8]);
   assign off   = mem_addr_i[7:0];

`ifdef MMIO_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_nxt;
   logic        shadow_we;
`endif

   always_comb begin
      state_d  = state_q;
      rd_en    = 1'b0;
      idx_we   = 1'b0;
      resp_ld  = 1'b0;
      resp_err = 1'b0;
      resp_dat = 32'h0;
`ifdef MMIO_SNAPSHOT_EN
      shadow_we  = 1'b0;
      shadow_nxt = 32'h0;
`endif
      case (state_q)
         IDLE: begin
            if (hit) begin
               if (is_wr) begin
                  // A write wins over a simultaneous read; only a full-word write to the index is legal.
                  resp_ld = 1'b1;
                  state_d = RESP;
                  if (off == 8'h30 && mem_wr_i == 4'hF) idx_we = 1'b1;
                  else                                  resp_err = 1'b1;
               end else if (off == 8'h28 || off == 8'h2C) begin
                  rd_en   = 1'b1;
                  state_d = RAM_WAIT;
               end else begin
                  resp_ld = 1'b1;
                  state_d = RESP;
                  case (off)
                     8'h00: resp_dat = mcycle_i[31:0];
                     8'h08: resp_dat = minstret_i[31:0];
                     8'h10: resp_dat = stall_i[31:0];
`ifdef MMIO_SNAPSHOT_EN
                     8'h04, 8'h0C, 8'h14: resp_dat = shadow_q;
`else
                     8'h04: resp_dat = mcycle_i[63:32];
                     8'h0C: resp_dat = minstret_i[63:32];
                     8'h14: resp_dat = stall_i[63:32];
`endif
                     8'h20: resp_dat = {31'b0, trace_triggered_i};
                     8'h24: resp_dat = {{(32-TRACE_DEPTH_W){1'b0}}, trace_wr_ptr_i};
                     8'h30: resp_dat = {{(32-TRACE_DEPTH_W){1'b0}}, index_q};
                     default: resp_err = 1'b1;
                  endcase
`ifdef MMIO_SNAPSHOT_EN
                  // Lo reads capture the matching hi half so the next hi read is coherent.
                  case (off)
                     8'h00: begin shadow_we = 1'b1; shadow_nxt = mcycle_i[63:32];   end
                     8'h08: begin shadow_we = 1'b1; shadow_nxt = minstret_i[63:32]; end
                     8'h10: begin shadow_we = 1'b1; shadow_nxt = stall_i[63:32];    end
                     default: ;
                  endcase
`endif
               end
            end
         end
         RAM_WAIT: begin
            resp_ld  = 1'b1;
            resp_dat = sel_instr_q ? trace_rd_instr_i : trace_rd_pc_i;
            state_d  = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         index_q     <= '0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         sel_instr_q <= 1'b0;
`ifdef MMIO_SNAPSHOT_EN
         shadow_q    <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         if (idx_we)  index_q     <= mem_data_wr_i[TRACE_DEPTH_W-1:0];
         if (rd_en)   sel_instr_q <= off[2];
         if (resp_ld) begin
            rdata_q <= resp_dat;
            err_q   <= resp_err;
         end
`ifdef MMIO_SNAPSHOT_EN
         if (shadow_we) shadow_q <= shadow_nxt;
`endif
      end
   end

   assign mem_accept_o    = (state_q == IDLE);
   assign mem_ack_o       = (state_q == RESP);
   assign mem_error_o     = err_q;
   assign mem_data_rd_o   = rdata_q;
   assign trace_rd_en_o   = rd_en & ~rst_i;
   assign trace_rd_addr_o = index_q;

endmodule

// File: tb/tb_mmio_dbg_ctrl.sv
// Directed bench for mmio_dbg_ctrl: reset, index RW, trace reads, counter reads, errors, mid-transaction reset.
// Latency: checks ack position relative to the accept cycle.
// Backpressure: requests are only issued while the controller is idle.
module tb_mmio_dbg_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] mem_addr_i, mem_data_wr_i;
   logic        mem_rd_i;
   logic [3:0]  mem_wr_i;
   logic        mem_accept_o, mem_ack_o, mem_error_o;
   logic [31:0] mem_data_rd_o;
   logic [63:0] mcycle_i, minstret_i, stall_i;
   logic        trace_triggered_i;
   logic [5:0]  trace_wr_ptr_i;
   logic        trace_rd_en_o;
   logic [5:0]  trace_rd_addr_o;
   logic [31:0] trace_rd_pc_i, trace_rd_instr_i;

   always #5 clk_i = ~clk_i;

   mmio_dbg_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i),
      .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
      .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
      .mem_error_o(mem_error_o), .mem_data_rd_o(mem_data_rd_o),
      .mcycle_i(mcycle_i), .minstret_i(minstret_i), .stall_i(stall_i),
      .trace_triggered_i(trace_triggered_i), .trace_wr_ptr_i(trace_wr_ptr_i),
      .trace_rd_en_o(trace_rd_en_o), .trace_rd_addr_o(trace_rd_addr_o),
      .trace_rd_pc_i(trace_rd_pc_i), .trace_rd_instr_i(trace_rd_instr_i)
   );

   // Trace RAM model: synchronous read, data one cycle after the strobe.
   logic [31:0] ram_pc [64];
   logic [31:0] ram_instr [64];
   always @(posedge clk_i) begin
      if (trace_rd_en_o) begin
         trace_rd_pc_i    <= ram_pc[trace_rd_addr_o];
         trace_rd_instr_i <= ram_instr[trace_rd_addr_o];
      end
   end

   // Free-running cycle counter with a load port.
   logic        mc_ld = 1'b0;
   logic [63:0] mc_val = 64'h0;
   initial mcycle_i = 64'h0;
   always @(posedge clk_i) mcycle_i <= mc_ld ? mc_val : mcycle_i + 64'd1;

   int errors = 0;
   int checks = 0;

   logic        r_acc, r_en, r_err;
   int          r_lat;
   logic [31:0] r_dat;

   // One request, held for a single cycle starting after the next rising edge; waits up to 4 cycles for ack.
   task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic [3:0] wr);
      int n;
      @(posedge clk_i); #1;
      mem_addr_i = a; mem_data_wr_i = d; mem_rd_i = rd; mem_wr_i = wr;
      @(negedge clk_i);
      r_acc = mem_accept_o;
      r_en  = trace_rd_en_o;
      @(posedge clk_i); #1;
      mem_rd_i = 1'b0; mem_wr_i = 4'h0;
      r_lat = 0; r_dat = 32'hDEAD_BEEF; r_err = 1'bx; n = 0;
      while (r_lat == 0 && n < 4) begin
         @(negedge clk_i);
         n++;
         if (mem_ack_o === 1'b1) begin
            r_lat = n; r_dat = mem_data_rd_o; r_err = mem_error_o;
         end
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL rst_accept: got %b want 1", mem_accept_o); end
      checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", mem_ack_o); end
      checks++; if (mem_error_o !== 1'b0 || mem_data_rd_o !== 32'h0) begin errors++; $display("FAIL rst_resp: got err %b data %h want 0/0", mem_error_o, mem_data_rd_o); end
      checks++; if (trace_rd_en_o !== 1'b0 || trace_rd_addr_o !== 6'd0) begin errors++; $display("FAIL rst_trace: got en %b idx %0d want 0/0", trace_rd_en_o, trace_rd_addr_o); end
      @(posedge clk_i); #1 rst_i = 1'b0;
      bus_op(32'h8000_0030, 32'h0, 1'b1, 4'h0);
      checks++; if (r_acc !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL rst_idx_read_lat: got acc %b lat %0d want 1/1", r_acc, r_lat); end
      checks++; if (r_dat !== 32'h0 || r_err !== 1'b0) begin errors++; $display("FAIL rst_idx_read: got %h err %b want 00000000/0", r_dat, r_err); end
   endtask

   task automatic test_index;
      bus_op(32'h8000_0030, 32'hFFFF_FF05, 1'b0, 4'hF);
      checks++; if (r_lat !== 1 || r_err !== 1'b0) begin errors++; $display("FAIL idx_write: got lat %0d err %b want 1/0", r_lat, r_err); end
      bus_op(32'h8000_0030, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'h0000_0005) begin errors++; $display("FAIL idx_readback: got %h want 00000005", r_dat); end
      checks++; if (trace_rd_addr_o !== 6'd5) begin errors++; $display("FAIL idx_port: got %0d want 5", trace_rd_addr_o); end
   endtask

   task automatic test_trace;
      bus_op(32'h8000_0028, 32'h0, 1'b1, 4'h0);
      checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL trace_pc_en: got %b want 1", r_en); end
      checks++; if (r_lat !== 2 || r_dat !== 32'h0000_1234 || r_err !== 1'b0) begin errors++; $display("FAIL trace_pc: got lat %0d data %h err %b want 2/00001234/0", r_lat, r_dat, r_err); end
      bus_op(32'h8000_002C, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 2 || r_dat !== 32'h0010_0093) begin errors++; $display("FAIL trace_instr: got lat %0d data %h want 2/00100093", r_lat, r_dat); end
      bus_op(32'h8000_0024, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 1 || r_dat !== 32'h0000_002A) begin errors++; $display("FAIL wr_ptr: got lat %0d data %h want 1/0000002a", r_lat, r_dat); end
      bus_op(32'h8000_0020, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'h0000_0001) begin errors++; $display("FAIL triggered: got %h want 00000001", r_dat); end
   endtask

   // Lo read samples mcycle=0x1_FFFF_FFFF; the back-to-back hi read is accepted two cycles later (0x2_0000_0001).
   task automatic test_back_to_back;
      @(posedge clk_i); #1 mc_ld = 1'b1; mc_val = 64'h0000_0001_FFFF_FFFE;
      @(posedge clk_i); #1 mc_ld = 1'b0;
      bus_op(32'h8000_0000, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 1 || r_dat !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo: got lat %0d data %h want 1/ffffffff", r_lat, r_dat); end
      bus_op(32'h8000_0004, 32'h0, 1'b1, 4'h0);
      checks++; if (r_acc !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", r_acc); end
`ifdef MMIO_SNAPSHOT_EN
      checks++; if (r_dat !== 32'h0000_0001) begin errors++; $display("FAIL mcycle_hi: got %h want 00000001", r_dat); end
`else
      checks++; if (r_dat !== 32'h0000_0002) begin errors++; $display("FAIL mcycle_hi: got %h want 00000002", r_dat); end
`endif
      bus_op(32'h8000_0008, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'h5566_7788) begin errors++; $display("FAIL minstret_lo: got %h want 55667788", r_dat); end
      bus_op(32'h8000_000C, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'h1122_3344) begin errors++; $display("FAIL minstret_hi: got %h want 11223344", r_dat); end
      bus_op(32'h8000_0010, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'h0F0F_1234) begin errors++; $display("FAIL stall_lo: got %h want 0f0f1234", r_dat); end
      bus_op(32'h8000_0014, 32'h0, 1'b1, 4'h0);
      checks++; if (r_dat !== 32'hA5A5_0000) begin errors++; $display("FAIL stall_hi: got %h want a5a50000", r_dat); end
   endtask

   task automatic test_errors;
      bus_op(32'h8000_0000, 32'h1234_5678, 1'b0, 4'hF);
      checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_dat !== 32'h0) begin errors++; $display("FAIL wr_ro: got lat %0d err %b data %h want 1/1/0", r_lat, r_err, r_dat); end
      bus_op(32'h8000_0018, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_dat !== 32'h0) begin errors++; $display("FAIL rd_unmapped: got lat %0d err %b data %h want 1/1/0", r_lat, r_err, r_dat); end
      bus_op(32'h8000_0030, 32'h0000_003F, 1'b0, 4'h3);
      checks++; if (r_err !== 1'b1 || trace_rd_addr_o !== 6'd5) begin errors++; $display("FAIL wr_partial: got err %b idx %0d want 1/5", r_err, trace_rd_addr_o); end
      bus_op(32'h9000_0000, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 0) begin errors++; $display("FAIL non_hit: got ack after %0d cycles want none", r_lat); end
      // Read and write together: treated as a write.
      bus_op(32'h8000_0030, 32'h0000_0007, 1'b1, 4'hF);
      checks++; if (r_err !== 1'b0 || trace_rd_addr_o !== 6'd7) begin errors++; $display("FAIL rd_wr_both: got err %b idx %0d want 0/7", r_err, trace_rd_addr_o); end
   endtask

   task automatic test_reset_mid;
      int acks;
      @(posedge clk_i); #1;
      mem_addr_i = 32'h8000_0028; mem_rd_i = 1'b1;
      @(negedge clk_i);
      checks++; if (trace_rd_en_o !== 1'b1) begin errors++; $display("FAIL mid_en: got %b want 1", trace_rd_en_o); end
      @(posedge clk_i); #1 mem_rd_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i);
      checks++; if (mem_ack_o !== 1'b0 || mem_accept_o !== 1'b0) begin errors++; $display("FAIL mid_ram_wait: got ack %b acc %b want 0/0", mem_ack_o, mem_accept_o); end
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks++; if (mem_accept_o !== 1'b1 || trace_rd_en_o !== 1'b0 || trace_rd_addr_o !== 6'd0) begin errors++; $display("FAIL mid_after_rst: got acc %b en %b idx %0d want 1/0/0", mem_accept_o, trace_rd_en_o, trace_rd_addr_o); end
      acks = mem_ack_o ? 1 : 0;
      repeat (3) begin @(negedge clk_i); if (mem_ack_o) acks++; end
      checks++; if (acks !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
      bus_op(32'h8000_0030, 32'h0, 1'b1, 4'h0);
      checks++; if (r_lat !== 1 || r_dat !== 32'h0) begin errors++; $display("FAIL mid_idx: got lat %0d data %h want 1/0", r_lat, r_dat); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram_pc[i]    = 32'h0000_1000 + i;
         ram_instr[i] = 32'h0000_0013;
      end
      ram_pc[5]    = 32'h0000_1234;
      ram_instr[5] = 32'h0010_0093;
      mem_addr_i = 32'h0; mem_data_wr_i = 32'h0; mem_rd_i = 1'b0; mem_wr_i = 4'h0;
      minstret_i = 64'h1122_3344_5566_7788;
      stall_i    = 64'hA5A5_0000_0F0F_1234;
      trace_triggered_i = 1'b1;
      trace_wr_ptr_i    = 6'd42;
      rst_i = 1'b1;

      test_reset();
      test_index();
      test_trace();
      test_back_to_back();
      test_errors();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_dbg_ctrl.md
# mmio_dbg_ctrl

MMIO slave controller for the debug/telemetry window on the core data bus. It decodes word accesses in a 256-byte window, returns performance-counter values, and sequences reads of the trace buffer RAM through a programmable read index. It sits between the core data-bus interconnect and the telemetry counters and trace buffer. It owns the trace read port and the ack/response timing for the whole window.

## Interface
- BASE_ADDR, 32'h8000_0000: window base; only addr[31:8] is compared.
- TRACE_DEPTH_W, 6: trace buffer index width (64 entries).
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- mem_addr_i  in  32  request address (word aligned)
- mem_data_wr_i  in  32  write data
- mem_rd_i  in  1  read request
- mem_wr_i  in  4  byte write strobes; nonzero means write
- mem_accept_o  out  1  request accepted this cycle
- mem_ack_o  out  1  one-cycle response strobe
- mem_error_o  out  1  response error, valid with ack
- mem_data_rd_o  out  32  read data, valid with ack
- mcycle_i, minstret_i, stall_i  in  64 each  live counters
- trace_triggered_i  in  1  trace trigger flag
- trace_wr_ptr_i  in  TRACE_DEPTH_W  trace write pointer
- trace_rd_en_o  out  1  trace RAM read strobe
- trace_rd_addr_o  out  TRACE_DEPTH_W  trace read index (index register value)
- trace_rd_pc_i, trace_rd_instr_i  in  32 each  RAM data, valid 1 cycle after trace_rd_en_o

## Operation
- Hit: (mem_rd_i | mem_wr_i!=0) && mem_addr_i[31:8]==BASE_ADDR[31:8]. Non-hits are ignored: no accept, no ack.
- If both rd and wr are asserted, the request is a write.
- Register map (offset):
  - 0x00/0x04: mcycle lo/hi
  - 0x08/0x0C: minstret lo/hi
  - 0x10/0x14: stall lo/hi
  - 0x20: {31'b0, triggered}
  - 0x24: zero-extended wr_ptr
  - 0x28: trace PC at index
  - 0x2C: trace instr at index
  - 0x30: index (RW)
- Only 0x30 is writable, and only with mem_wr_i==4'b1111. The written value is data[TRACE_DEPTH_W-1:0]; upper bits are discarded.
- Partial-strobe write to 0x30, write to any other offset, or any access to an unmapped offset: acked with mem_error_o=1 and data 0. State is unchanged.
- FSM states: IDLE, RAM_WAIT, RESP.
  - IDLE: mem_accept_o=1. On a hit:
    - read of 0x28/0x2C: pulse trace_rd_en_o, go to RAM_WAIT.
    - any other hit: register the response, go to RESP.
  - RAM_WAIT: capture trace_rd_pc_i or trace_rd_instr_i per offset, go to RESP.
  - RESP: mem_ack_o=1 for one cycle, go to IDLE.
- One outstanding request. mem_accept_o=0 in RAM_WAIT and RESP; the bus must hold or retry.
- Counter reads sample the live inputs in the accept cycle.
- An index write and a trace read are never concurrent; a read after an index write sees the new index.

## Timing
- Reset values: mem_accept_o=1 (IDLE), mem_ack_o=0, mem_error_o=0, mem_data_rd_o=0, trace_rd_en_o=0, index=0, shadow=0.
- Latency, accept cycle T:
  - register read and any write: ack at T+1.
  - trace read: trace_rd_en_o at T, ack at T+2.
- mem_data_rd_o and mem_error_o are held until the next ack; they are meaningful only with ack.
- Reset asserted mid-transaction:
  - the FSM returns to IDLE next edge; the pending ack is dropped, never emitted.
  - the index and shadow clear.
- Back-to-back: a new request can be accepted the cycle after ack. Maximum throughput is one access per 2 cycles (register) or 3 cycles (trace).

## Configuration
- MMIO_SNAPSHOT_EN defined:
  - a lo read (0x00/0x08/0x10) latches the matching counter's [63:32] into one shared 32-bit shadow.
  - the following hi read (0x04/0x0C/0x14) returns the shadow, giving a coherent 64-bit value.
  - a hi read without a prior lo read returns the stale shadow (0 after reset).
- Undefined: hi reads return the live [63:32] at accept; no shadow register exists.

## Test plan
- After reset: read 0x8000_0030 -> ack at T+1, data 0x0000_0000, error 0.
- Write 0x8000_0030 = 0xFFFF_FF05 with strb 4'hF, then read 0x30:
  - the write acks with error 0.
  - the read returns 0x0000_0005.
  - trace_rd_addr_o=5.
- Index=5, RAM entry 5 = {pc 0x0000_1234, instr 0x0010_0093}:
  - read 0x28 -> trace_rd_en_o at T, ack at T+2, data 0x0000_1234.
  - read 0x2C -> data 0x0010_0093.
- mcycle=0x0000_0001_FFFF_FFFF, incrementing each cycle; read 0x00 then 0x04:
  - with MMIO_SNAPSHOT_EN: 0xFFFF_FFFx, then 0x0000_0001.
  - without: hi reflects the live value, 0x0000_0002 if it wrapped between the reads.
- Error and ignore cases:
  - write 0x8000_0000 -> ack, error 1, counter unaffected.
  - read 0x8000_0018 -> ack, error 1, data 0.
  - read 0x9000_0000 -> no accept, no ack.
- Assert rst_i in RAM_WAIT -> no ack emitted, trace_rd_en_o=0, accept=1 next cycle, index reads 0.
